game_pixel_pipe: RTL and testbench



---
 rtl/game_pixel_pipe_pkg.sv | 30 +++
 rtl/game_pixel_pipe_fade_scaler.sv | 28 ++
 rtl/game_pixel_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_game_pixel_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pixel_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the game pixel pipeline: game-state
//                encodings, fade sequencer states and the full-scale colour
//                helper.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Game-state encodings as presented on the state input
    localparam logic [1:0] MENU   = 2'b00;
    localparam logic [1:0] ON     = 2'b01;
    localparam logic [1:0] UNUSED = 2'b10;
    localparam logic [1:0] OVER   = 2'b11;

    // Fade transition sequencer
    typedef enum logic [1:0] {
        STEADY   = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_t;

    // All-ones value for a colour channel of width w (1..8), right-aligned
    function automatic logic [7:0] full_color(input int unsigned w);
        full_color = 8'hFF >> (8 - w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_pixel_pipe_fade_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : fade_scaler
//  Description : One colour channel scaled by the fade level:
//                o_color = (i_color * i_level) >> SHIFT, full product width
//                then truncated. With i_level = 2**SHIFT the input passes
//                through unchanged.
//  Ports       : i_color  [COLOR_W-1:0] channel value
//                i_level  [LEVEL_W-1:0] fade level, 0..2**SHIFT
//                o_color  [COLOR_W-1:0] scaled channel value
//  Revision    : 1.0  initial release
// ============================================================================
module fade_scaler #(
    parameter int COLOR_W = 8,
    parameter int LEVEL_W = 5,
    parameter int SHIFT   = 4
) (
    input  logic [COLOR_W-1:0] i_color,
    input  logic [LEVEL_W-1:0] i_level,
    output logic [COLOR_W-1:0] o_color
);

    localparam int c_prod_w = COLOR_W + LEVEL_W;

    assign o_color = COLOR_W'((c_prod_w'(i_color) * c_prod_w'(i_level)) >> SHIFT);

endmodule
`default_nettype wire

// File: rtl/game_pixel_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : game_pixel_pipe
//  Description : Two-stage registered pixel colouriser between the VGA timing
//                generator and the colour DAC. Stage 1 picks the scene colour
//                for the currently shown game state, stage 2 applies the fade
//                level and blanking. A game-state change fades the old scene
//                out and the new one in, one level step per frame.
//  Ports       : clk, reset          pixel clock, synchronous active-high reset
//                video_on            active-video flag
//                frame_start         one pulse per frame
//                x_coord, y_coord    pixel coordinates (10 bits each)
//                state               requested game state
//                red, green, blue    colour outputs (COLOR_W bits each)
//                pix_valid           video_on delayed by two cycles
//                busy                fade transition in progress
//  Options     : GAME_PIXEL_BLANK_DEBUG_EN - blanked pixels drive full white
//                instead of black (scope timing aid); ports are unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module game_pixel_pipe
    import game_pkg::*;
#(
    parameter int COLOR_W      = 8,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int FADE_FRAMES  = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic               frame_start,
    input  logic [9:0]         x_coord,
    input  logic [9:0]         y_coord,
    input  logic [1:0]         state,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               pix_valid,
    output logic               busy
);

    localparam int c_shift   = $clog2(FADE_FRAMES);
    localparam int c_level_w = c_shift + 1;

    localparam logic [c_level_w-1:0] c_level_full = c_level_w'(FADE_FRAMES);
    localparam logic [c_level_w-1:0] c_level_one  = c_level_w'(1);

    localparam logic [COLOR_W-1:0] c_full = COLOR_W'(full_color(COLOR_W));
    localparam logic [COLOR_W-1:0] c_zero = '0;
    localparam logic [COLOR_W-1:0] c_dim  = COLOR_W'(1);

    // Scene geometry, all bounds exclusive
    localparam logic [9:0] c_box_x_lo   = 10'(H_ACTIVE / 4);
    localparam logic [9:0] c_box_x_hi   = 10'((3 * H_ACTIVE) / 4);
    localparam logic [9:0] c_box_y_lo   = 10'(V_ACTIVE / 4);
    localparam logic [9:0] c_box_y_hi   = 10'((3 * V_ACTIVE) / 4);
    localparam logic [9:0] c_strip_x_lo = 10'(H_ACTIVE / 8);
    localparam logic [9:0] c_strip_x_hi = 10'((7 * H_ACTIVE) / 8);

    localparam logic [7:0] c_blink_last = 8'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    fade_state_t          r_fsm,   w_fsm_d;
    logic [c_level_w-1:0] r_level, w_level_d;
    logic [1:0]           r_shown, w_shown_d;
    logic [1:0]           r_target, w_target_d;
    logic [7:0]           r_blink_cnt, w_blink_cnt_d;
    logic                 r_blink, w_blink_d;

    always_comb begin
        w_fsm_d    = r_fsm;
        w_level_d  = r_level;
        w_shown_d  = r_shown;
        w_target_d = r_target;

        case (r_fsm)
            STEADY: begin
                w_level_d = c_level_full;
                // The level does not step on the cycle the change is seen
                if (state != r_shown) begin
                    w_target_d = state;
                    w_fsm_d    = FADE_OUT;
                end
            end
            FADE_OUT: begin
                w_target_d = state;
                if (state == r_shown) begin
                    // Request withdrawn: climb back from the current level
                    w_fsm_d = FADE_IN;
                end else if (frame_start) begin
                    if (r_level <= c_level_one) begin
                        // Screen is black: swap scenes behind it
                        w_level_d = '0;
                        w_shown_d = r_target;
                        w_fsm_d   = FADE_IN;
                    end else begin
                        w_level_d = r_level - c_level_one;
                    end
                end
            end
            FADE_IN: begin
                if (state != r_shown) begin
                    w_target_d = state;
                    w_fsm_d    = FADE_OUT;
                end else if (frame_start) begin
                    // Saturate at full scale; also covers an abort before any step
                    if (r_level >= c_level_full - c_level_one) begin
                        w_level_d = c_level_full;
                        w_fsm_d   = STEADY;
                    end else begin
                        w_level_d = r_level + c_level_one;
                    end
                end
            end
            default: begin
                w_fsm_d   = STEADY;
                w_level_d = c_level_full;
            end
        endcase
    end

    // Menu-box blink runs only while the menu is the visible scene
    always_comb begin
        w_blink_cnt_d = r_blink_cnt;
        w_blink_d     = r_blink;
        if (r_shown != MENU) begin
            w_blink_cnt_d = '0;
            w_blink_d     = 1'b1;
        end else if (frame_start) begin
            if (r_blink_cnt == c_blink_last) begin
                w_blink_cnt_d = '0;
                w_blink_d     = ~r_blink;
            end else begin
                w_blink_cnt_d = r_blink_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: scene colour
    // ------------------------------------------------------------------
    logic w_in_box, w_in_strip;
    logic [COLOR_W-1:0] w_s1_r, w_s1_g, w_s1_b;

    assign w_in_box   = (x_coord > c_box_x_lo) && (x_coord < c_box_x_hi) &&
                        (y_coord > c_box_y_lo) && (y_coord < c_box_y_hi);
    assign w_in_strip = (x_coord > c_strip_x_lo) && (x_coord < c_strip_x_hi);

    always_comb begin
        w_s1_r = c_zero;
        w_s1_g = c_zero;
        w_s1_b = c_zero;
        case (r_shown)
            MENU: begin
                if (r_blink && w_in_box) w_s1_r = c_full;
                else                     w_s1_b = c_full;
            end
            ON: begin
                if (!w_in_strip) w_s1_g = c_full;
            end
            OVER: begin
                w_s1_r = c_full;
            end
            default: begin
                w_s1_r = c_dim;
                w_s1_g = c_dim;
                w_s1_b = c_dim;
            end
        endcase
    end

    logic [2:0][COLOR_W-1:0] r_s1_col;
    logic                    r_s1_vid;

    // ------------------------------------------------------------------
    // Stage 2: fade scaling and blanking
    // ------------------------------------------------------------------
    logic [2:0][COLOR_W-1:0] w_scaled;
    logic [2:0][COLOR_W-1:0] w_s2_col;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_chan
            fade_scaler #(
                .COLOR_W (COLOR_W),
                .LEVEL_W (c_level_w),
                .SHIFT   (c_shift)
            ) u_scaler (
                .i_color (r_s1_col[i]),
                .i_level (r_level),
                .o_color (w_scaled[i])
            );
        end
    endgenerate

    always_comb begin
        w_s2_col = w_scaled;
        if (!r_s1_vid) begin
`ifdef GAME_PIXEL_BLANK_DEBUG_EN
            w_s2_col = {3{c_full}};
`else
            w_s2_col = {3{c_zero}};
`endif
        end
    end

    logic [2:0][COLOR_W-1:0] r_s2_col;
    logic                    r_pix_valid;
    logic                    r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= STEADY;
            r_level     <= c_level_full;
            r_shown     <= MENU;
            r_target    <= MENU;
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
            r_s1_col    <= '0;
            r_s1_vid    <= 1'b0;
            r_s2_col    <= '0;
            r_pix_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_d;
            r_level     <= w_level_d;
            r_shown     <= w_shown_d;
            r_target    <= w_target_d;
            r_blink_cnt <= w_blink_cnt_d;
            r_blink     <= w_blink_d;
            r_s1_col    <= {w_s1_r, w_s1_g, w_s1_b};
            r_s1_vid    <= video_on;
            r_s2_col    <= w_s2_col;
            r_pix_valid <= r_s1_vid;
            r_busy      <= (w_fsm_d != STEADY);
        end
    end

    assign red       = r_s2_col[2];
    assign green     = r_s2_col[1];
    assign blue      = r_s2_col[0];
    assign pix_valid = r_pix_valid;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_game_pixel_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_pixel_pipe
//  Description : Self-checking bench for game_pixel_pipe with FADE_FRAMES=4,
//                BLINK_FRAMES=2, COLOR_W=8 at 640x480.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_pixel_pipe;

    localparam int c_fade = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic       frame_start;
    logic [9:0] x_coord;
    logic [9:0] y_coord;
    logic [1:0] state;
    logic [7:0] red, green, blue;
    logic       pix_valid;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    game_pixel_pipe #(
        .COLOR_W      (8),
        .H_ACTIVE     (640),
        .V_ACTIVE     (480),
        .FADE_FRAMES  (c_fade),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .frame_start (frame_start),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .state       (state),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pix_valid   (pix_valid),
        .busy        (busy)
    );

    typedef struct {
        logic [1:0]  scene;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[16];
    logic [1:0] cur_scene;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One frame pulse, then let the pipeline settle before sampling
    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic goto_scene(input logic [1:0] s);
        state = s;
        tick();
        repeat (2 * c_fade) pulse();
        chk("transition_done_busy", {23'd0, busy}, 24'd0);
        cur_scene = s;
    endtask

    initial begin
        // scene, x, y, expected {r,g,b}; menu rows rely on blink still set
        vecs[0]  = '{2'b00, 10'd320, 10'd240, 24'hFF0000};
        vecs[1]  = '{2'b00, 10'd10,  10'd10,  24'h0000FF};
        vecs[2]  = '{2'b00, 10'd160, 10'd240, 24'h0000FF};
        vecs[3]  = '{2'b00, 10'd161, 10'd240, 24'hFF0000};
        vecs[4]  = '{2'b00, 10'd479, 10'd240, 24'hFF0000};
        vecs[5]  = '{2'b00, 10'd480, 10'd240, 24'h0000FF};
        vecs[6]  = '{2'b00, 10'd320, 10'd120, 24'h0000FF};
        vecs[7]  = '{2'b00, 10'd320, 10'd121, 24'hFF0000};
        vecs[8]  = '{2'b00, 10'd320, 10'd360, 24'h0000FF};
        vecs[9]  = '{2'b01, 10'd80,  10'd5,   24'h00FF00};
        vecs[10] = '{2'b01, 10'd81,  10'd5,   24'h000000};
        vecs[11] = '{2'b01, 10'd559, 10'd400, 24'h000000};
        vecs[12] = '{2'b01, 10'd560, 10'd400, 24'h00FF00};
        vecs[13] = '{2'b11, 10'd0,   10'd0,   24'hFF0000};
        vecs[14] = '{2'b11, 10'd639, 10'd479, 24'hFF0000};
        vecs[15] = '{2'b10, 10'd5,   10'd5,   24'h010101};

        reset = 1'b1; video_on = 1'b1; frame_start = 1'b0;
        x_coord = 10'd320; y_coord = 10'd240; state = 2'b00;
        cur_scene = 2'b00;

        // Reset state
        tick(); tick(); tick();
        chk("reset_rgb", {red, green, blue}, 24'h000000);
        chk("reset_flags", {22'd0, pix_valid, busy}, 24'd0);
        reset = 1'b0;
        tick(); tick();
        chk("post_reset_box", {red, green, blue}, 24'hFF0000);
        chk("post_reset_flags", {22'd0, pix_valid, busy}, 24'd2);

        // Scene geometry table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].scene != cur_scene) goto_scene(vecs[i].scene);
            x_coord = vecs[i].x;
            y_coord = vecs[i].y;
            tick(); tick();
            chk($sformatf("scene_vec%0d", i), {red, green, blue}, vecs[i].rgb);
        end

        // Back to menu: blink=1, counter=0 after the fade-in pulses
        goto_scene(2'b00);
        x_coord = 10'd320; y_coord = 10'd240;
        tick(); tick();
        chk("blink_start", {red, green, blue}, 24'hFF0000);
        pulse();
        chk("blink_p1", {red, green, blue}, 24'hFF0000);
        pulse();
        chk("blink_off", {red, green, blue}, 24'h0000FF);
        pulse(); pulse();
        chk("blink_on", {red, green, blue}, 24'hFF0000);

        // Uninterrupted MENU->ON fade at the box pixel; blink keeps toggling
        // while the menu is still shown, so the box vanishes after frame 2
        state = 2'b01;
        tick();
        chk("fade_busy_start", {23'd0, busy}, 24'd1);
        pulse(); chk("fade_out1", {red, green, blue}, 24'hBF0000);
        pulse(); chk("fade_out2", {red, green, blue}, 24'h00007F);
        pulse(); chk("fade_out3", {red, green, blue}, 24'h00003F);
        pulse(); chk("fade_out4", {red, green, blue}, 24'h000000);
        tick(); tick();
        chk("on_strip_black", {red, green, blue}, 24'h000000);
        x_coord = 10'd10; y_coord = 10'd10;
        pulse(); chk("fade_in1", {red, green, blue}, 24'h003F00);
        chk("fade_in1_busy", {23'd0, busy}, 24'd1);
        pulse(); chk("fade_in2", {red, green, blue}, 24'h007F00);
        pulse(); chk("fade_in3", {red, green, blue}, 24'h00BF00);
        chk("fade_in3_busy", {23'd0, busy}, 24'd1);
        pulse(); chk("fade_in4", {red, green, blue}, 24'h00FF00);
        chk("fade_in4_busy", {23'd0, busy}, 24'd0);
        cur_scene = 2'b01;

        // Abort: request ON, then withdraw it at level 2
        goto_scene(2'b00);
        x_coord = 10'd10; y_coord = 10'd10;
        state = 2'b01;
        tick();
        pulse(); pulse();
        chk("abort_lvl2", {red, green, blue}, 24'h00007F);
        state = 2'b00;
        tick(); tick();
        chk("abort_fadein_lvl2", {red, green, blue}, 24'h00007F);
        chk("abort_busy", {23'd0, busy}, 24'd1);
        pulse();
        chk("abort_lvl3", {red, green, blue}, 24'h0000BF);
        chk("abort_busy3", {23'd0, busy}, 24'd1);
        pulse();
        chk("abort_done", {red, green, blue}, 24'h0000FF);
        chk("abort_busy_clear", {23'd0, busy}, 24'd0);

        // Blanking inside the box, exactly two cycles of latency
        x_coord = 10'd320; y_coord = 10'd240;
        tick(); tick();
        video_on = 1'b0;
        tick();
        chk("blank_valid_lat1", {23'd0, pix_valid}, 24'd1);
        tick();
        chk("blank_valid_lat2", {23'd0, pix_valid}, 24'd0);
`ifdef GAME_PIXEL_BLANK_DEBUG_EN
        chk("blank_rgb", {red, green, blue}, 24'hFFFFFF);
`else
        chk("blank_rgb", {red, green, blue}, 24'h000000);
`endif
        video_on = 1'b1;
        tick(); tick();

        // Reset in the middle of a fade at level 1
        state = 2'b01;
        tick();
        pulse(); pulse(); pulse();
        chk("pre_reset_lvl1", {red, green, blue}, 24'h000000 | {16'd0, 8'h3F} | 24'h000000);
        reset = 1'b1;
        state = 2'b00;
        tick();
        chk("midfade_reset_rgb", {red, green, blue}, 24'h000000);
        chk("midfade_reset_flags", {22'd0, pix_valid, busy}, 24'd0);
        reset = 1'b0;
        tick(); tick();
        chk("midfade_recover", {red, green, blue}, 24'hFF0000);
        chk("midfade_recover_busy", {23'd0, busy}, 24'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
